// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port, byte-addressed data memory between the
// pipeline MEM stage (port C, priority) and a word-burst DMA/loader (port D).
// Port C is passed straight through while idle. A granted DMA burst owns the
// memory for len beats plus one DONE cycle, stalling any C request meanwhile.
// A starvation counter forces a pending DMA request in after STARVE_MAX refusals.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   cpu_req/we/addr/din/ctrl       MEM stage access (zero-latency)
//   cpu_dout, cpu_stall            load data (pass-through), stall request
//   dma_req/we/addr/len/wdata      burst request, sampled at grant
//   dma_beat, dma_rdata, dma_done  per-beat strobe, read word, end pulse
//   mem_we/addr/din/ctrl, mem_dout memory interface
module dm_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned LEN_W      = 4,
  parameter logic [2:0]  DM_WORD    = 3'b000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_din,
  input  logic [2:0]       cpu_ctrl,
  output logic [31:0]      cpu_dout,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_addr,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wdata,
  output logic             dma_beat,
  output logic [31:0]      dma_rdata,
  output logic             dma_done,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic [2:0]       mem_ctrl,
  input  logic [31:0]      mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t         r_state;
  logic [7:0]     r_starve;
  logic [LEN_W:0] r_beat;
  logic [LEN_W:0] r_len;
  logic [31:0]    r_base;
  logic           r_we;

  logic           w_grant;
  logic [LEN_W:0] w_len_in;
  logic           w_last;
  logic [31:0]    w_beat_bytes;
  logic [9:0]     w_burst_idx;
  logic [31:0]    w_burst_addr;

  // A C request blocks the grant unless the DMA side has waited its limit.
  assign w_grant  = (r_state == S_IDLE) && dma_req &&
                    (!cpu_req || (r_starve == 8'(STARVE_MAX)));
  // Length 0 encodes the maximum burst of 2^LEN_W words.
  assign w_len_in = (dma_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, dma_len};
  assign w_last   = (r_beat == (r_len - {{LEN_W{1'b0}}, 1'b1}));

  // Burst addresses wrap within the 1 KiB memory; upper bits follow the base.
  assign w_beat_bytes = 32'({r_beat, 2'b00});
  assign w_burst_idx  = r_base[9:0] + w_beat_bytes[9:0];
  assign w_burst_addr = {r_base[31:10], w_burst_idx};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
      r_beat   <= '0;
      r_len    <= '0;
      r_base   <= '0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_base   <= dma_addr & 32'hFFFF_FFFC;
            r_len    <= w_len_in;
            r_we     <= dma_we;
            r_starve <= '0;
            r_beat   <= '0;
            r_state  <= S_BURST;
          end else if (dma_req && (r_starve != 8'(STARVE_MAX))) begin
            r_starve <= r_starve + 8'd1;
          end
        end
        S_BURST: begin
          r_beat <= r_beat + {{LEN_W{1'b0}}, 1'b1};
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_beat  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we    = cpu_req & cpu_we;
    mem_addr  = cpu_addr;
    mem_din   = cpu_din;
    mem_ctrl  = cpu_ctrl;
    cpu_stall = 1'b0;
    dma_beat  = 1'b0;
    dma_done  = 1'b0;
    case (r_state)
      S_BURST: begin
        mem_we    = r_we;
        mem_addr  = w_burst_addr;
        mem_din   = dma_wdata;
        mem_ctrl  = DM_WORD;
        cpu_stall = cpu_req;
        dma_beat  = 1'b1;
      end
      S_DONE: begin
        mem_we    = 1'b0;
        mem_addr  = w_burst_addr;
        mem_din   = dma_wdata;
        mem_ctrl  = DM_WORD;
        cpu_stall = cpu_req;
        dma_done  = 1'b1;
      end
      default: ;
    endcase
    // Write enable is held off for the whole time reset is asserted.
    if (!rstn) begin
      mem_we = 1'b0;
    end
  end

  assign cpu_dout  = mem_dout;
  assign dma_rdata = mem_dout;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Arbiter and sequencer that shares the single-port, byte-addressed data memory between the pipeline MEM stage (port C) and a word-burst DMA/loader port (port D). It sits between the MEM stage, the DMA engine and the data memory, and drives the memory's write enable, address, write data and access-size control. The MEM stage has priority. A starvation counter bounds DMA wait time. While a DMA burst is active, the arbiter stalls the pipeline.

## Interface
- STARVE_MAX, 8: cycles a pending DMA request may be refused before it is forced in (1..255)
- LEN_W, 4: width of the burst-length field; length 0 means 2^LEN_W words
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous, active-low reset
- cpu_req  input  1  MEM stage access valid this cycle
- cpu_we  input  1  MEM stage store (1) / load (0)
- cpu_addr  input  32  MEM stage byte address
- cpu_din  input  32  store data
- cpu_ctrl  input  3  access size, the codebase's `dm_word`/`dm_halfword`/`dm_byte` encoding
- cpu_dout  output  32  load data (memory read data, passed through)
- cpu_stall  output  1  MEM stage must hold its request and freeze
- dma_req  input  1  burst request; held high until dma_done
- dma_we  input  1  burst is write (1) / read (0); sampled at grant
- dma_addr  input  32  burst start byte address; sampled at grant
- dma_len  input  LEN_W  burst length in words; sampled at grant
- dma_wdata  input  32  write word for current beat
- dma_beat  output  1  one word transferred this cycle
- dma_rdata  output  32  read word, valid when dma_beat && !dma_we
- dma_done  output  1  one-cycle pulse after the last beat
- mem_we  output  1  to memory write enable
- mem_addr  output  32  to memory address
- mem_din  output  32  to memory write data
- mem_ctrl  output  3  to memory access size
- mem_dout  input  32  memory combinational read data

## Operation
- States: IDLE, BURST, DONE.
- IDLE:
  - The memory outputs mirror port C: mem_we = cpu_req & cpu_we, mem_addr = cpu_addr, mem_din = cpu_din, mem_ctrl = cpu_ctrl.
  - cpu_stall = 0.
- Grant rule in IDLE: if dma_req && (!cpu_req || starve == STARVE_MAX), latch base = {dma_addr[31:2], 2'b00}, len = (dma_len == 0 ? 2^LEN_W : dma_len) and we_l = dma_we, then go to BURST.
  - A C access in the grant cycle still completes in that cycle.
- Starve counter: increments in IDLE each cycle dma_req is high and no grant is given. It saturates at STARVE_MAX and clears on grant.
- BURST:
  - cpu_stall = cpu_req.
  - mem_addr = base + 4·beat, with the 10-bit memory index wrapping mod 1024.
  - mem_ctrl = `dm_word`, mem_we = we_l, mem_din = dma_wdata.
  - dma_beat = 1 every cycle; dma_rdata = mem_dout.
  - The beat counter increments each cycle. When beat == len−1, go to DONE.
- DONE:
  - dma_done = 1 and mem_we = 0.
  - Port C is not served; cpu_stall = cpu_req.
  - Next state is IDLE.
  - If dma_req is still high in IDLE the next cycle, it is a new burst and is arbitrated normally with starve = 0.
- cpu_dout = mem_dout in all states. It is only meaningful to the MEM stage when cpu_stall = 0.

## Timing
- Reset (rstn low, asynchronous):
  - State IDLE; starve, beat, base, len and we_l cleared.
  - mem_we is forced 0 combinationally while rstn = 0.
  - dma_beat = 0, dma_done = 0, cpu_stall = 0.
- Port C latency: zero cycles.
  - Load data is combinational in the request cycle.
  - A store is written at the next rising edge.
- DMA latency:
  - Grant edge to first beat: 1 cycle.
  - An N-word burst occupies N BURST cycles plus 1 DONE cycle.
  - Worst-case wait from dma_req rise to grant: STARVE_MAX+1 cycles.
- Port C worst-case stall: 2^LEN_W+1 cycles.
- Reset mid-burst: the burst is abandoned, no dma_done is issued, and no further writes occur. The DMA engine must re-request.
- dma_req dropping mid-burst is illegal. The burst still runs to completion.

## Test plan
- C only: cpu_req=1, cpu_we=1, addr 0x10, ctrl word, din 0xDEADBEEF; then a load from 0x10 → cpu_dout 0xDEADBEEF, cpu_stall=0 throughout.
- DMA write burst, C idle: dma_addr 0x20, len 4, wdata 1,2,3,4 → grant next edge, dma_beat for 4 cycles at mem_addr 0x20/24/28/2C, dma_done 1 cycle later; C reads return 1..4.
- Starvation: cpu_req held 1 continuously, dma_req raised at cycle 0 with STARVE_MAX=8 → grant at the edge ending cycle 8, cpu_stall=1 for len+1 cycles, then C resumes.
- Wrap and alignment: dma_addr 0x3FE, len 2, read → base forced to 0x3FC, beats at index 0x3FC then 0x000.
- len=0 → 16 beats, dma_done on the 17th cycle after grant.
- Reset asserted at beat 2 of an 8-word write → no memory writes after reset edge, outputs at reset values, dma_done never pulses; state is IDLE after release.
